// File: rtl/uart_voice_pkg.sv
// Shared definitions for the voice-synthesis frame sender.
//   FRAME_HDR  : first byte of every frame
//   HDR_BYTES  : fixed header bytes ahead of the payload (FD, len_hi, len_lo, CMD, PARAM)
//   state_t    : frame sequencer FSM states
//   frame_len  : total bytes on the wire for a payload length
package uart_voice_pkg;

  localparam logic [7:0]  FRAME_HDR = 8'hFD;
  localparam int unsigned HDR_BYTES = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    SEND,
    WAIT
  } state_t;

  function automatic logic [15:0] frame_len(input logic [15:0] len, input logic xor_en);
    frame_len = 16'(HDR_BYTES) + len + {15'd0, xor_en};
  endfunction

endpackage

// File: rtl/msg_req_fifo.sv
// Pending message-ID queue.
//   clk, rstn : clock, asynchronous active-low reset
//   push      : write push_id (caller guarantees !full or a same-cycle pop)
//   pop       : discard head (caller guarantees !empty)
//   head      : oldest queued ID
//   full/empty: occupancy flags
// QDEPTH must be a power of 2, at least 2.
module msg_req_fifo #(
  parameter int unsigned ID_W   = 2,
  parameter int unsigned QDEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic [ID_W-1:0] head,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PW = $clog2(QDEPTH);

  logic [ID_W-1:0] mem [QDEPTH];
  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // When full, a push lands in the slot being popped; head is read before the edge.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= push_id;
  end

endmodule

// File: rtl/uart_frame_sequencer.sv
// Queued, table-driven frame sender for the serial voice-synthesis module.
// Frame: FD, len_hi, len_lo, CMD_BYTE, PARAM_BYTE, payload from ROM
// [, XOR of all previous bytes when FRAME_XOR_EN is defined].
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   req[N_MSG]           : play-request pulses (lowest index wins)
//   req_drop             : 1-cycle pulse when a request is discarded
//   busy                 : frame in progress or queue non-empty
//   desc_id              : ID whose descriptor is being loaded
//   desc_base, desc_len  : payload descriptor for desc_id (combinational)
//   rom_addr, rom_data   : payload ROM, data valid 1 cycle after address
//   SendEn/SendData      : byte strobe to the UART TX
//   SendDone             : UART TX finished the byte
// Build option: FRAME_XOR_EN appends a checksum byte.
module uart_frame_sequencer
  import uart_voice_pkg::*;
#(
  parameter int unsigned N_MSG      = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned QDEPTH     = 4,
  parameter logic [7:0]  CMD_BYTE   = 8'h01,
  parameter logic [7:0]  PARAM_BYTE = 8'h01,
  parameter bit          BOOT_REQ   = 1'b1,
  parameter int unsigned BOOT_ID    = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_MSG-1:0]  req,
  output logic              req_drop,
  output logic              busy,
  output logic [ID_W-1:0]   desc_id,
  input  logic [ADDR_W-1:0] desc_base,
  input  logic [LEN_W-1:0]  desc_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              SendEn,
  output logic [7:0]        SendData,
  input  logic              SendDone
);

`ifdef FRAME_XOR_EN
  localparam logic XOR_EN = 1'b1;
`else
  localparam logic XOR_EN = 1'b0;
`endif

  state_t            state, state_n;
  logic [15:0]       idx;
  logic [15:0]       total_q;
  logic [15:0]       len_field;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        data_q;
  logic [7:0]        byte_sel;
  logic              boot_pend;
  logic              busy_q;
  logic              drop_q;
`ifdef FRAME_XOR_EN
  logic [7:0]        xor_q;
`endif

  // Request decode and queue admission
  logic            any_req, multi_req;
  logic [ID_W-1:0] req_id;
  logic            want_push, accept, push, pop, drop;
  logic [ID_W-1:0] push_id, head;
  logic            full, empty;

  always_comb begin
    req_id    = '0;
    any_req   = 1'b0;
    multi_req = 1'b0;
    for (int unsigned i = 0; i < N_MSG; i++) begin
      if (req[i]) begin
        if (any_req) multi_req = 1'b1;
        else         req_id    = ID_W'(i);
        any_req = 1'b1;
      end
    end
  end

  // Boot request occupies the push slot on its cycle; any req alongside it is dropped.
  always_comb begin
    want_push = boot_pend | any_req;
    push_id   = boot_pend ? ID_W'(BOOT_ID) : req_id;
    accept    = !full || pop;
    push      = want_push && accept;
    drop      = (want_push && !accept) || (boot_pend && any_req) || multi_req;
  end

  msg_req_fifo #(
    .ID_W   (ID_W),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push),
    .push_id (push_id),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  // Byte mux
  assign len_field = total_q - 16'd3;

  always_comb begin
    byte_sel = rom_data;
    if      (idx == 16'd0) byte_sel = FRAME_HDR;
    else if (idx == 16'd1) byte_sel = len_field[15:8];
    else if (idx == 16'd2) byte_sel = len_field[7:0];
    else if (idx == 16'd3) byte_sel = CMD_BYTE;
    else if (idx == 16'd4) byte_sel = PARAM_BYTE;
`ifdef FRAME_XOR_EN
    else if (idx == total_q - 16'd1) byte_sel = xor_q;
`endif
  end

  assign rom_addr = (idx >= 16'(HDR_BYTES)) ? base_q + ADDR_W'(idx - 16'(HDR_BYTES)) : '0;
  assign SendEn   = (state == SEND);
  // Live mux while strobing, then the registered copy holds until the next SEND.
  assign SendData = (state == SEND) ? byte_sel : data_q;
  assign busy     = busy_q;
  assign req_drop = drop_q;

  // FSM
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD:  state_n = FETCH;
      FETCH: state_n = SEND;
      SEND:  state_n = WAIT;
      WAIT: begin
        if (SendDone) state_n = (idx + 16'd1 == total_q) ? IDLE : FETCH;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      boot_pend <= BOOT_REQ;
      desc_id   <= '0;
      base_q    <= '0;
      total_q   <= '0;
      idx       <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
`ifdef FRAME_XOR_EN
      xor_q     <= '0;
`endif
    end else begin
      boot_pend <= 1'b0;
      busy_q    <= (state != IDLE) || !empty;
      drop_q    <= drop;
      if (pop) desc_id <= head;
      if (state == LOAD) begin
        base_q  <= desc_base;
        total_q <= frame_len(16'(desc_len), XOR_EN);
        idx     <= '0;
`ifdef FRAME_XOR_EN
        xor_q   <= '0;
`endif
      end
      if (state == SEND) begin
        data_q <= byte_sel;
`ifdef FRAME_XOR_EN
        xor_q  <= xor_q ^ byte_sel;
`endif
      end
      if (state == WAIT && SendDone) idx <= idx + 16'd1;
    end
  end

endmodule
